// File: rtl/display_timing_gen_if.sv
// Scan-timing bundle from the raster generator to the map RAM / colour pipeline.
interface display_timing_gen_if;
  logic        hsync;
  logic        vsync;
  logic        enableVideo;
  logic [9:0]  pixelRow;
  logic [9:0]  pixelColumn;
  logic [14:0] worldAddr;
  logic        frameStart;

  modport master (
    output hsync, vsync, enableVideo, pixelRow, pixelColumn, worldAddr, frameStart
  );

  modport slave (
    input  hsync, vsync, enableVideo, pixelRow, pixelColumn, worldAddr, frameStart
  );
endinterface

// File: rtl/display_timing_gen.sv
// VGA raster counters with video-enable and sync outputs delay-matched to the
// map RAM read and the registered colour stage.
module display_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned VID_DLY  = 1,
  parameter int unsigned SYNC_DLY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  display_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       frame_start_q, frame_start_d;
  logic       active, hs_raw, vs_raw;

  always_comb begin
    col_d = (col_q == H_LAST) ? '0 : col_q + 10'd1;
    row_d = row_q;
    if (col_q == H_LAST) begin
      row_d = (row_q == V_LAST) ? '0 : row_q + 10'd1;
    end
    // Registered decode of the next position, so the pulse lines up with (0,0).
    frame_start_d = (col_d == '0) && (row_d == '0);
    active = (col_q < H_ACT) && (row_q < V_ACT);
    hs_raw = !((col_q >= HS_BEG) && (col_q <= HS_END));
    vs_raw = !((row_q >= VS_BEG) && (row_q <= VS_END));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b1;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
    end
  end

  generate
    if (VID_DLY == 0) begin : g_vid_pass
      assign vga.enableVideo = active;
    end else begin : g_vid_pipe
      logic [VID_DLY-1:0] vid_q, vid_d;
      always_comb begin
        vid_d[0] = active;
        for (int unsigned i = 1; i < VID_DLY; i++) vid_d[i] = vid_q[i-1];
      end
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vid_q <= '0;
        else          vid_q <= vid_d;
      end
      assign vga.enableVideo = vid_q[VID_DLY-1];
    end

    if (SYNC_DLY == 0) begin : g_sync_pass
      assign vga.hsync = hs_raw;
      assign vga.vsync = vs_raw;
    end else begin : g_sync_pipe
      logic [SYNC_DLY-1:0] hs_q, hs_d, vs_q, vs_d;
      always_comb begin
        hs_d[0] = hs_raw;
        vs_d[0] = vs_raw;
        for (int unsigned i = 1; i < SYNC_DLY; i++) begin
          hs_d[i] = hs_q[i-1];
          vs_d[i] = vs_q[i-1];
        end
      end
      // Reset to idle-high so a reset mid-pulse releases sync immediately.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_q <= '1;
          vs_q <= '1;
        end else begin
          hs_q <= hs_d;
          vs_q <= vs_d;
        end
      end
      assign vga.hsync = hs_q[SYNC_DLY-1];
      assign vga.vsync = vs_q[SYNC_DLY-1];
    end
  endgenerate

  assign vga.pixelRow    = row_q;
  assign vga.pixelColumn = col_q;
  assign vga.worldAddr   = {row_q[8:2], col_q[9:2]};
  assign vga.frameStart  = frame_start_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench: full 640x480 instance for line timing, reduced-geometry
// instance (25x15 raster) for frame, window, wrap and mid-frame reset.
module tb_display_timing_gen;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #20 clk = ~clk;

  display_timing_gen_if vf();
  display_timing_gen_if vsm();

  display_timing_gen u_full (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (vf)
  );

  // H: 16+2+4+3 = 25, hsync low cols 18..21; V: 8+2+2+3 = 15, vsync low rows 10..11.
  display_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
    .VID_DLY  (1),  .SYNC_DLY (2)
  ) u_small (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (vsm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    logic fh_prev;
    int   fh_fall1, fh_fall2, fh_rise, f_en_line, f_fs;
    int   s_en, s_en_first, s_en_last, s_vs_cnt, s_vs_first, s_fs1, s_fs2;
    logic addr_hit, found;

    fh_fall1 = -1; fh_fall2 = -1; fh_rise = -1; f_en_line = 0; f_fs = 0;
    s_en = 0; s_en_first = -1; s_en_last = -1; s_vs_cnt = 0; s_vs_first = -1;
    s_fs1 = -1; s_fs2 = -1; addr_hit = 1'b0; found = 1'b0;

    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_col",   32'(vf.pixelColumn), 32'd0);
    check("rst_row",   32'(vf.pixelRow),    32'd0);
    check("rst_en",    32'(vf.enableVideo), 32'd0);
    check("rst_hs",    32'(vf.hsync),       32'd1);
    check("rst_vs",    32'(vf.vsync),       32'd1);
    check("rst_fs",    32'(vf.frameStart),  32'd1);
    check("rst_addr",  32'(vf.worldAddr),   32'd0);
    check("rst_s_hs",  32'(vsm.hsync),      32'd1);
    check("rst_s_vs",  32'(vsm.vsync),      32'd1);
    check("rst_s_fs",  32'(vsm.frameStart), 32'd1);

    // Counters sit at (0,0) now; k counts clocks from this cycle.
    reset_n = 1'b1;
    fh_prev = vf.hsync;
    for (int k = 1; k <= 5700; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("first_col", 32'(vf.pixelColumn), 32'd1);
        check("first_row", 32'(vf.pixelRow),    32'd0);
        check("first_en",  32'(vf.enableVideo), 32'd1);
      end
      if (vf.hsync == 1'b0 && fh_prev == 1'b1) begin
        if (fh_fall1 < 0)      fh_fall1 = k;
        else if (fh_fall2 < 0) fh_fall2 = k;
      end
      if (vf.hsync == 1'b1 && fh_prev == 1'b0 && fh_rise < 0) fh_rise = k;
      fh_prev = vf.hsync;
      if (k <= 800 && vf.enableVideo) f_en_line++;
      if (vf.frameStart) f_fs++;
      if (vf.pixelRow == 10'd7 && vf.pixelColumn == 10'd13) begin
        addr_hit = 1'b1;
        check("addr_7_13", 32'(vf.worldAddr), 32'({7'd1, 8'd3}));
      end

      if (k <= 375) begin
        if (vsm.enableVideo) begin
          s_en++;
          if (s_en_first < 0) s_en_first = k;
          s_en_last = k;
        end
        if (!vsm.vsync) begin
          s_vs_cnt++;
          if (s_vs_first < 0) s_vs_first = k;
        end
      end
      if (vsm.frameStart) begin
        if (s_fs1 < 0)      s_fs1 = k;
        else if (s_fs2 < 0) s_fs2 = k;
      end
      if (k == 374) begin
        check("wrap_pre_row", 32'(vsm.pixelRow),    32'd14);
        check("wrap_pre_col", 32'(vsm.pixelColumn), 32'd24);
        check("addr_14_24",   32'(vsm.worldAddr),   32'({7'd3, 8'd6}));
        check("wrap_pre_fs",  32'(vsm.frameStart),  32'd0);
      end
      if (k == 375) begin
        check("wrap_row", 32'(vsm.pixelRow),    32'd0);
        check("wrap_col", 32'(vsm.pixelColumn), 32'd0);
        check("wrap_fs",  32'(vsm.frameStart),  32'd1);
      end
    end

    check("hs_fall",      32'(fh_fall1),            32'd658);
    check("hs_width",     32'(fh_rise - fh_fall1),  32'd96);
    check("hs_period",    32'(fh_fall2 - fh_fall1), 32'd800);
    check("en_per_line",  32'(f_en_line),           32'd640);
    check("full_no_fs",   32'(f_fs),                32'd0);
    check("addr_reached", 32'(addr_hit),            32'd1);
    check("s_en_count",   32'(s_en),                32'd128);
    check("s_en_first",   32'(s_en_first),          32'd1);
    check("s_en_last",    32'(s_en_last),           32'd191);
    check("s_vs_count",   32'(s_vs_cnt),            32'd50);
    check("s_vs_first",   32'(s_vs_first),          32'd252);
    check("s_fs_first",   32'(s_fs1),               32'd375);
    check("s_fs_period",  32'(s_fs2 - s_fs1),       32'd375);

    // Mid-frame reset while both syncs of the small raster are low.
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (vsm.pixelRow == 10'd11 && vsm.pixelColumn == 10'd20) found = 1'b1;
    end
    check("midrst_reach", 32'(found),      32'd1);
    check("midrst_hs_lo", 32'(vsm.hsync),  32'd0);
    check("midrst_vs_lo", 32'(vsm.vsync),  32'd0);
    reset_n = 1'b0;
    #1;
    check("midrst_col", 32'(vsm.pixelColumn), 32'd0);
    check("midrst_row", 32'(vsm.pixelRow),    32'd0);
    check("midrst_hs",  32'(vsm.hsync),       32'd1);
    check("midrst_vs",  32'(vsm.vsync),       32'd1);
    check("midrst_fs",  32'(vsm.frameStart),  32'd1);
    check("midrst_en",  32'(vsm.enableVideo), 32'd0);
    check("midrst_fcol", 32'(vf.pixelColumn), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    s_fs1 = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("restart_col", 32'(vsm.pixelColumn), 32'd1);
        check("restart_row", 32'(vsm.pixelRow),    32'd0);
      end
      if (vsm.frameStart && s_fs1 < 0) s_fs1 = k;
    end
    check("restart_fs", 32'(s_fs1), 32'd375);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_timing_gen.md
# display_timing_gen

Generates 640x480 @ 60 Hz VGA scan timing and drives the pixel-pipeline control inputs of the colorizer stage. It runs on the 25 MHz pixel clock. It outputs the raster position, the world-map read address, and a video-enable and sync signals that are delay-matched to the downstream pipeline: a one-cycle map RAM read followed by the one-cycle registered colour stage. It sits between the clock generator and the map RAM / icon / colour logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- VID_DLY, 1, register stages on enableVideo (matches map RAM latency)
- SYNC_DLY, 2, register stages on hsync/vsync (matches RAM + colour register)
- clk  in  1  pixel clock, 25 MHz, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- enableVideo  out  1  high when the pixel presented VID_DLY cycles ago is in the visible area
- pixelRow  out  10  current vertical count, undelayed
- pixelColumn  out  10  current horizontal count, undelayed
- worldAddr  out  15  {pixelRow[8:2], pixelColumn[9:2]}, undelayed; 4x4 screen pixels per map cell
- frameStart  out  1  one-cycle pulse when the counters are at (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Counters are 10 bits wide, unsigned.
- pixelColumn counts 0..H_TOTAL-1 and wraps to 0.
- pixelRow increments only in the cycle where pixelColumn == H_TOTAL-1. It wraps from V_TOTAL-1 to 0 on that same cycle.
- Raw decodes are combinational from the counters:
  - active = (col < H_ACTIVE) && (row < V_ACTIVE)
  - hs_raw low for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751]
  - vs_raw low for row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491], for entire lines
- enableVideo = active through VID_DLY registers. hsync/vsync = hs_raw/vs_raw through SYNC_DLY registers. Delays of 0 mean pass-through.
- worldAddr is a pure bit-select of the undelayed counters. Row bit 9 is always 0 in the active area. Outside the active area worldAddr is don't-care but must still follow the formula.
- frameStart is registered: it is high in the cycle where (row,col) == (0,0).
- No external enable and no stall; the counters free-run.

## Timing
- Reset (async assert, any time):
  - pixelColumn = 0, pixelRow = 0
  - all delay registers cleared: enableVideo = 0, hsync = 1, vsync = 1
  - frameStart = 1 (counters are at (0,0))
- Reset deassert is synchronised by the reset generator upstream.
- First clock edge after deassert: counters advance to (0,1).
- Mid-frame reset restarts the frame at (0,0) immediately. No partial sync pulse may persist: hsync/vsync return to 1 asynchronously.
- Frame length: exactly 420000 clocks between frameStart pulses.
- Latency: pixel (r,c) → enableVideo after VID_DLY clocks; → hsync/vsync after SYNC_DLY clocks.
- Delay pipelines are not flushed on counter wrap; outputs stay continuous across line and frame boundaries.

## Test plan
- Reset: hold reset_n low for 5 clocks, with a mid-frame assert repeated at row 300, col 400 → all outputs show reset values within the same cycle, and the next frame begins at (0,0).
- Line timing: release reset, count clocks → hsync falls 658 clocks after the (0,0) cycle, stays low for exactly 96 clocks, and period = 800.
- Frame timing: run 2 frames → frameStart pulses exactly 420000 clocks apart; vsync low for exactly 1600 clocks, starting 2 clocks after counter (490,0).
- Video window: count enableVideo highs → 640 per visible line, 307200 per frame. The first high comes 1 clock after (0,0); the last is 1 clock after (479,639); zero during rows 480..524.
- Address mapping: sample at (row,col) = (7,13), (479,639), (0,0) → worldAddr = {7'd1,8'd3}, {7'd119,8'd159}, 0.
- Wrap: observe transition (524,799) → (0,0) → pixelRow and pixelColumn both wrap in the same cycle, with frameStart high in that (0,0) cycle.
